// File: rtl/keyscan_evq_if.sv
// Single-beat Wishbone register port of the key event queue.
// Master drives address/data/strobe; slave returns registered data and a one-cycle ack.
interface keyscan_evq_if;
  logic [1:0]  wb_addr;
  logic [31:0] wb_rdata;
  logic [31:0] wb_wdata;
  logic        wb_we;
  logic        wb_cyc;
  logic        wb_ack;

  modport master (output wb_addr, output wb_wdata, output wb_we, output wb_cyc,
                  input  wb_rdata, input wb_ack);
  modport slave  (input  wb_addr, input wb_wdata, input wb_we, input wb_cyc,
                  output wb_rdata, output wb_ack);
endinterface

// File: rtl/keyscan_evq.sv
// Key event scheduler: per frame strobe, scans one key per cycle against the last reported state
// and queues press/release events; key k of a frame strobed in T is readable from T+2+k.
module keyscan_evq #(
  parameter int NROWS      = 4,
  parameter int NCOLS      = 12,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NROWS*NCOLS-1:0] km_state,
  input  logic                   km_stb,
  keyscan_evq_if.slave           wb,
  output logic                   irq
);
  localparam int NK = NROWS * NCOLS;
  localparam int IW = (NK > 1) ? $clog2(NK) : 1;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic {IDLE, SCAN} state_t;

  state_t          state_q, state_d;
  logic [NK-1:0]   snap_q, snap_d, prev_q, prev_d;
  logic [15:0]     ts_q, ts_d, frame_q, frame_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [3:0]      row_q, row_d, col_q, col_d;
  logic            enable_q, enable_d, irq_en_q, irq_en_d, ovf_q, ovf_d;
  logic            ack_q, ack_d, pop_pend_q, pop_pend_d, irq_q, irq_d;
  logic [31:0]     rdata_q, rdata_d;
  logic [AW-1:0]   wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [31:0]     mem [FIFO_DEPTH];

  logic            acc_start, acc_done, csr_wr, flush, pop, push, push_eff, ovf_set;
  logic            full, empty;
  logic [31:0]     evt, rd_mux;
  logic [7:0]      level;
  logic            unused_wdata;

  assign unused_wdata = ^wb.wb_wdata[31:4];

  assign acc_start = wb.wb_cyc & ~ack_q;
  assign acc_done  = wb.wb_cyc & ack_q;
  assign csr_wr    = acc_done & wb.wb_we & (wb.wb_addr == 2'd0);
  assign flush     = csr_wr & wb.wb_wdata[3];
  // Pop only what was actually returned when the read was captured.
  assign pop       = acc_done & pop_pend_q;
  assign full      = (count_q == CW'(FIFO_DEPTH));
  assign empty     = (count_q == '0);
  assign level     = 8'(count_q);
  assign evt       = {1'b1, snap_q[idx_q], 2'b00, row_q, 4'b0000, col_q, ts_q};

  always_comb begin
    state_d = state_q;
    snap_d  = snap_q;
    prev_d  = prev_q;
    ts_d    = ts_q;
    idx_d   = idx_q;
    row_d   = row_q;
    col_d   = col_q;
    push    = 1'b0;
    ovf_set = 1'b0;
    case (state_q)
      IDLE: begin
        if (km_stb && enable_q) begin
          snap_d  = km_state;
          ts_d    = frame_q;
          idx_d   = '0;
          row_d   = '0;
          col_d   = '0;
          state_d = SCAN;
        end
      end
      SCAN: begin
        if (!enable_q) begin
          state_d = IDLE;
        end else begin
          if (snap_q[idx_q] != prev_q[idx_q]) begin
            // A full FIFO leaves prev untouched so the change is re-detected next frame.
            if (!full) begin
              push          = 1'b1;
              prev_d[idx_q] = snap_q[idx_q];
            end else begin
              ovf_set = 1'b1;
            end
          end
          if (idx_q == IW'(NK - 1)) begin
            state_d = IDLE;
          end else begin
            idx_d = idx_q + IW'(1);
            if (col_q == 4'(NCOLS - 1)) begin
              col_d = '0;
              row_d = row_q + 4'd1;
            end else begin
              col_d = col_q + 4'd1;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    push_eff = push & ~flush;
    wptr_d   = wptr_q;
    rptr_d   = rptr_q;
    count_d  = count_q;
    if (flush) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (push_eff) wptr_d = wptr_q + AW'(1);
      if (pop)      rptr_d = rptr_q + AW'(1);
      case ({push_eff, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_comb begin
    enable_d = csr_wr ? wb.wb_wdata[0] : enable_q;
    irq_en_d = csr_wr ? wb.wb_wdata[1] : irq_en_q;
    ovf_d    = ovf_q;
    if (csr_wr && wb.wb_wdata[2]) ovf_d = 1'b0;
    if (ovf_set)                  ovf_d = 1'b1;
    frame_d  = (km_stb && enable_q) ? frame_q + 16'd1 : frame_q;
    case (wb.wb_addr)
      2'd0:    rd_mux = {16'h0000, level, 5'b00000, ovf_q, irq_en_q, enable_q};
      2'd1:    rd_mux = empty ? 32'h0 : mem[rptr_q];
      2'd2:    rd_mux = {16'h0000, frame_q};
      default: rd_mux = 32'h0;
    endcase
    ack_d      = acc_start;
    rdata_d    = acc_start ? rd_mux : 32'h0;
    pop_pend_d = acc_start & ~wb.wb_we & (wb.wb_addr == 2'd1) & ~empty;
    irq_d      = irq_en_q & (!empty | ovf_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      snap_q     <= '0;
      prev_q     <= '0;
      ts_q       <= '0;
      frame_q    <= '0;
      idx_q      <= '0;
      row_q      <= '0;
      col_q      <= '0;
      enable_q   <= 1'b0;
      irq_en_q   <= 1'b0;
      ovf_q      <= 1'b0;
      ack_q      <= 1'b0;
      pop_pend_q <= 1'b0;
      irq_q      <= 1'b0;
      rdata_q    <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      snap_q     <= snap_d;
      prev_q     <= prev_d;
      ts_q       <= ts_d;
      frame_q    <= frame_d;
      idx_q      <= idx_d;
      row_q      <= row_d;
      col_q      <= col_d;
      enable_q   <= enable_d;
      irq_en_q   <= irq_en_d;
      ovf_q      <= ovf_d;
      ack_q      <= ack_d;
      pop_pend_q <= pop_pend_d;
      irq_q      <= irq_d;
      rdata_q    <= rdata_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count_q    <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_eff) mem[wptr_q] <= evt;
  end

  assign wb.wb_ack   = ack_q;
  assign wb.wb_rdata = rdata_q;
  assign irq         = irq_q;
endmodule
